// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-rate divider, x/y scan counters, sync decode and
// a one-pixel-deep registered output stage that blanks colour outside the visible area.
module vga_sync_gen #(
  parameter int H_DISP  = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_DISP  = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int PIX_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] rgb_in,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       pix_tick,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic [2:0] rgb_out,
  output logic       frame_tick
);

  localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

  localparam logic [9:0] H_LAST   = 10'(H_DISP + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISP);
  localparam logic [9:0] HS_BEGIN = 10'(H_DISP + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_DISP + H_FP + H_SYNC);
  localparam logic [9:0] V_LAST   = 10'(V_DISP + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] V_VIS    = 10'(V_DISP);
  localparam logic [9:0] VS_BEGIN = 10'(V_DISP + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_DISP + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_cnt;
  logic             x_wrap;
  logic             y_wrap;
  logic             vis;
  logic             hs_n;
  logic             vs_n;

  assign pix_tick = (div_cnt == DIV_LAST);

  // Using >= lets any out-of-range count fall back to 0 on the next tick.
  assign x_wrap = (x >= H_LAST);
  assign y_wrap = (y >= V_LAST);

  assign vis  = (x < H_VIS) && (y < V_VIS);
  assign hs_n = !((x >= HS_BEGIN) && (x < HS_END));
  assign vs_n = !((y >= VS_BEGIN) && (y < VS_END));

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt    <= '0;
      x          <= '0;
      y          <= '0;
      video_on   <= 1'b0;
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      rgb_out    <= 3'b000;
      frame_tick <= 1'b0;
    end else begin
      div_cnt    <= pix_tick ? '0 : div_cnt + DIV_W'(1);
      frame_tick <= pix_tick && (x == H_LAST) && (y == V_LAST);
      // Outputs capture the coordinate of the pixel period that is ending,
      // so the DAC trails x/y by exactly one pixel.
      if (pix_tick) begin
        video_on <= vis;
        hsync    <= hs_n;
        vsync    <= vs_n;
        rgb_out  <= vis ? rgb_in : 3'b000;
        if (x_wrap) begin
          x <= '0;
          y <= y_wrap ? 10'd0 : y + 10'd1;
        end else begin
          x <= x + 10'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: default timing at PIX_DIV=4 and 1, plus a
// shrunken timing instance so whole frames and mid-frame reset fit in a short run.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b, rst_c;
  logic [2:0] rgb_a, rgb_b, rgb_c;

  logic [9:0] x_a, y_a, x_b, y_b, x_c, y_c;
  logic       pix_tick_a, video_on_a, hsync_a, vsync_a, frame_tick_a;
  logic       pix_tick_b, video_on_b, hsync_b, vsync_b, frame_tick_b;
  logic       pix_tick_c, video_on_c, hsync_c, vsync_c, frame_tick_c;
  logic [2:0] rgb_out_a, rgb_out_b, rgb_out_c;

  int total = 0;
  int bad   = 0;
  int cnt;
  int vs_low, hs_low, vid, ft, rgb_err;

  vga_sync_gen dut_a (
    .clk(clk), .rst(rst_a), .rgb_in(rgb_a), .x(x_a), .y(y_a),
    .pix_tick(pix_tick_a), .video_on(video_on_a), .hsync(hsync_a),
    .vsync(vsync_a), .rgb_out(rgb_out_a), .frame_tick(frame_tick_a)
  );

  // 15 x 8 total, 8 x 4 visible, hsync at x=10..12, vsync at y=5..6.
  vga_sync_gen #(
    .H_DISP(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_DISP(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .PIX_DIV(2)
  ) dut_b (
    .clk(clk), .rst(rst_b), .rgb_in(rgb_b), .x(x_b), .y(y_b),
    .pix_tick(pix_tick_b), .video_on(video_on_b), .hsync(hsync_b),
    .vsync(vsync_b), .rgb_out(rgb_out_b), .frame_tick(frame_tick_b)
  );

  vga_sync_gen #(.PIX_DIV(1)) dut_c (
    .clk(clk), .rst(rst_c), .rgb_in(rgb_c), .x(x_c), .y(y_c),
    .pix_tick(pix_tick_c), .video_on(video_on_c), .hsync(hsync_c),
    .vsync(vsync_c), .rgb_out(rgb_out_c), .frame_tick(frame_tick_c)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      $error("[TB] assertion %s", tag);
    end
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    rgb_a = 3'b111; rgb_b = 3'b101; rgb_c = 3'b000;
    repeat (3) @(posedge clk);
    @(negedge clk);

    check_output("rst_x", x_a, 0);
    check_output("rst_y", y_a, 0);
    check_output("rst_pix_tick", pix_tick_a, 0);
    check_output("rst_video_on", video_on_a, 0);
    check_output("rst_hsync", hsync_a, 1);
    check_output("rst_vsync", vsync_a, 1);
    check_output("rst_rgb_out", rgb_out_a, 0);
    check_output("rst_frame_tick", frame_tick_a, 0);

    // Sample n is the n-th clk cycle after release; the first tick lands in cycle 4.
    rst_a = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      check_output("div_pix_tick", pix_tick_a, (n % 4 == 0));
      check_output("div_x", x_a, (n - 1) / 4);
      check_output("div_video_on", video_on_a, (n > 4));
      check_output("div_rgb_out", rgb_out_a, (n > 4) ? 7 : 0);
      check_output("div_hsync", hsync_a, 1);
      check_output("div_vsync", vsync_a, 1);
      check_output("div_frame_tick", frame_tick_a, 0);
      step();
    end

    cnt = 0;
    while (hsync_a && cnt < 4000) begin step(); cnt++; end
    check_output("hs_fall_seen", hsync_a, 0);
    check_output("hs_fall_x", x_a, 657);
    check_output("hs_fall_y", y_a, 0);
    cnt = 0;
    while (!hsync_a && cnt < 1000) begin step(); cnt++; end
    check_output("hs_low_clks", cnt, 384);
    check_output("hs_rise_x", x_a, 753);

    cnt = 0;
    while (x_a != 10'd799 && cnt < 1000) begin step(); cnt++; end
    check_output("wrap_x799", x_a, 799);
    check_output("wrap_y0", y_a, 0);
    repeat (4) step();
    check_output("wrap_x0", x_a, 0);
    check_output("wrap_y1", y_a, 1);
    cnt = 0;
    while (y_a != 10'd2 && cnt < 4000) begin step(); cnt++; end
    check_output("line_clks", cnt, 3200);
    check_output("line_x0", x_a, 0);

    cnt = 0;
    while (x_a != 10'd639 && cnt < 4000) begin step(); cnt++; end
    check_output("align_x639", x_a, 639);
    rgb_a = 3'b010;
    check_output("align_rgb_old", rgb_out_a, 7);
    repeat (4) step();
    check_output("align_x640", x_a, 640);
    check_output("align_rgb_new", rgb_out_a, 2);
    check_output("align_vid_on", video_on_a, 1);
    repeat (4) step();
    check_output("blank_rgb", rgb_out_a, 0);
    check_output("blank_vid_off", video_on_a, 0);
    rgb_a = 3'b111;

    // Small-timing instance: one frame is 15*8*2 = 240 clks.
    rst_b = 1'b0;
    cnt = 0;
    while (!frame_tick_b && cnt < 500) begin step(); cnt++; end
    check_output("ft_first_clks", cnt, 240);
    check_output("ft_first_x", x_b, 0);
    check_output("ft_first_y", y_b, 0);
    cnt = 0; vs_low = 0; hs_low = 0; vid = 0; ft = 0; rgb_err = 0;
    do begin
      step();
      cnt++;
      if (!vsync_b) vs_low++;
      if (!hsync_b) hs_low++;
      if (video_on_b) vid++;
      if (frame_tick_b) ft++;
      if (rgb_out_b !== (video_on_b ? 3'b101 : 3'b000)) rgb_err++;
    end while (!frame_tick_b && cnt < 500);
    check_output("frame_clks", cnt, 240);
    check_output("frame_ft_count", ft, 1);
    check_output("frame_vs_low", vs_low, 60);
    check_output("frame_hs_low", hs_low, 48);
    check_output("frame_video_on", vid, 64);
    check_output("frame_rgb_blank", rgb_err, 0);
    step();
    check_output("ft_one_clk", frame_tick_b, 0);

    cnt = 0;
    while (!(x_b == 10'd12 && y_b == 10'd5) && cnt < 500) begin step(); cnt++; end
    check_output("mid_x", x_b, 12);
    check_output("mid_y", y_b, 5);
    check_output("mid_hsync_low", hsync_b, 0);
    check_output("mid_vsync_low", vsync_b, 0);
    rst_b = 1'b1;
    step();
    rst_b = 1'b0;
    check_output("mid_rst_x", x_b, 0);
    check_output("mid_rst_y", y_b, 0);
    check_output("mid_rst_hsync", hsync_b, 1);
    check_output("mid_rst_vsync", vsync_b, 1);
    check_output("mid_rst_rgb", rgb_out_b, 0);
    check_output("mid_rst_pix_tick", pix_tick_b, 0);
    step();
    check_output("mid_next_tick", pix_tick_b, 1);
    check_output("mid_x_hold", x_b, 0);
    step();
    check_output("mid_x_adv", x_b, 1);

    // Default timing with PIX_DIV=1: every clk is a pixel.
    rst_c = 1'b0;
    for (int n = 0; n < 3; n++) begin
      check_output("div1_tick", pix_tick_c, 1);
      step();
    end
    cnt = 0;
    while (hsync_c && cnt < 2000) begin step(); cnt++; end
    check_output("div1_hs_fall_x", x_c, 657);
    cnt = 0;
    while (!hsync_c && cnt < 2000) begin step(); cnt++; end
    check_output("div1_hs_low", cnt, 96);
    cnt = 0;
    while (x_c != 10'd799 && cnt < 2000) begin step(); cnt++; end
    check_output("div1_x799", x_c, 799);
    step();
    check_output("div1_wrap_x", x_c, 0);
    check_output("div1_wrap_y", y_c, 1);
    cnt = 0;
    while (y_c != 10'd2 && cnt < 2000) begin step(); cnt++; end
    check_output("div1_line_clks", cnt, 800);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
